// File: rtl/point_multiplier_seq_pkg.sv
// ---------------------------------------------------------------------------
// point_multiplier_seq_pkg
//
// Shared definitions for the sequential elliptic-curve scalar multiplier:
//   - DATAWIDTH: default coordinate / scalar width.
//   - Curve constants for y^2 = x^3 + A*x + B over GF(P), plus the generator G.
//   - Infinity encoding (0,0). (0,0) is never a curve point because B != 0.
//   - FSM state encodings for the multiplier controller.
// No ports; imported by every file of the block.
// ---------------------------------------------------------------------------
package point_multiplier_seq_pkg;

  localparam int DATAWIDTH = 8;

  // Curve y^2 = x^3 + x + 250 (mod 251), generator G = (2,3).
  localparam logic [DATAWIDTH-1:0] CURVE_P = 8'd251;
  localparam logic [DATAWIDTH-1:0] CURVE_A = 8'd1;
  localparam logic [DATAWIDTH-1:0] CURVE_B = 8'd250;
  localparam logic [DATAWIDTH-1:0] GEN_X   = 8'd2;
  localparam logic [DATAWIDTH-1:0] GEN_Y   = 8'd3;

  // Point at infinity, shared by the adder and the multiplier.
  localparam logic [DATAWIDTH-1:0] INF_X = '0;
  localparam logic [DATAWIDTH-1:0] INF_Y = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DBL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/point_multiplier_seq_adder.sv
// ---------------------------------------------------------------------------
// point_multiplier_seq_adder
//
// Combinational affine point adder S = A + B on the package curve.
// Handles doubling (A == B) and all infinity cases:
//   A = inf -> B;  B = inf -> A;  A = -B (incl. doubling with y = 0) -> inf.
// The modular inverse uses Fermat (d^(P-2)), unrolled MSB-first as a
// square-and-multiply chain, so the whole adder settles in one cycle.
//
// Ports:
//   ax, ay  in  WIDTH  first operand
//   bx, by  in  WIDTH  second operand
//   sx, sy  out WIDTH  sum
// ---------------------------------------------------------------------------
module point_multiplier_seq_adder
  import point_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = DATAWIDTH
) (
  input  logic [WIDTH-1:0] ax,
  input  logic [WIDTH-1:0] ay,
  input  logic [WIDTH-1:0] bx,
  input  logic [WIDTH-1:0] by,
  output logic [WIDTH-1:0] sx,
  output logic [WIDTH-1:0] sy
);

  localparam logic [WIDTH-1:0] P       = WIDTH'(CURVE_P);
  localparam logic [WIDTH-1:0] A       = WIDTH'(CURVE_A);
  localparam logic [WIDTH-1:0] INV_EXP = P - WIDTH'(2);

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + {1'b0, P} - {1'b0, b};
    return d[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] rem;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    rem  = prod % {{WIDTH{1'b0}}, P};
    return rem[WIDTH-1:0];
  endfunction

  logic             a_inf;
  logic             b_inf;
  logic             same_x;
  logic             is_dbl;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] den_inv;
  logic [WIDTH-1:0] lambda;
  logic [WIDTH-1:0] x3;
  logic [WIDTH-1:0] y3;

  assign a_inf  = (ax == WIDTH'(INF_X)) && (ay == WIDTH'(INF_Y));
  assign b_inf  = (bx == WIDTH'(INF_X)) && (by == WIDTH'(INF_Y));
  assign same_x = (ax == bx);
  assign is_dbl = same_x && (ay == by);

  // One shared slope computation: tangent for doubling, chord otherwise.
  always_comb begin
    num = mod_sub(by, ay);
    den = mod_sub(bx, ax);
    if (is_dbl) begin
      num = mod_add(mod_mul(mod_mul(ax, ax), WIDTH'(3)), A);
      den = mod_add(ay, ay);
    end
  end

  // den^(P-2) mod P, one exponent bit per stage, MSB first.
  // den = 0 only on paths whose result is overridden below.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_inv
      logic [WIDTH-1:0] acc_in;
      logic [WIDTH-1:0] acc_sq;
      logic [WIDTH-1:0] acc_out;
      if (gi == 0) begin : g_first
        assign acc_in = WIDTH'(1);
      end else begin : g_chain
        assign acc_in = g_inv[gi-1].acc_out;
      end
      assign acc_sq  = mod_mul(acc_in, acc_in);
      assign acc_out = INV_EXP[WIDTH-1-gi] ? mod_mul(acc_sq, den) : acc_sq;
    end
  endgenerate

  assign den_inv = g_inv[WIDTH-1].acc_out;
  assign lambda  = mod_mul(num, den_inv);
  // For doubling bx == ax, so the generic x3 formula covers both cases.
  assign x3      = mod_sub(mod_sub(mod_mul(lambda, lambda), ax), bx);
  assign y3      = mod_sub(mod_mul(lambda, mod_sub(ax, x3)), ay);

  always_comb begin
    sx = x3;
    sy = y3;
    if (a_inf) begin
      sx = bx;
      sy = by;
    end else if (b_inf) begin
      sx = ax;
      sy = ay;
    end else if (same_x && !(is_dbl && (ay != '0))) begin
      // Opposite points, or doubling a point of order two.
      sx = WIDTH'(INF_X);
      sy = WIDTH'(INF_Y);
    end
  end

endmodule

// File: rtl/point_multiplier_seq.sv
// ---------------------------------------------------------------------------
// point_multiplier_seq
//
// Sequential scalar multiplier R = n*Q using one time-multiplexed point
// adder. Two adder cycles per scalar bit (MSB first), then one FIN cycle:
// fixed latency of 2*WIDTH+1 cycles regardless of n.
//   LADDER = 0: double-and-add (DBL then ADD per bit; ADD result selected
//               by k[i] after the adder has evaluated R0+B).
//   LADDER = 1: Montgomery ladder (ADD then DBL per bit).
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only while ready
//   n        in   WIDTH  scalar, sampled with start
//   Qx, Qy   in   WIDTH  base point, sampled with start
//   ready    out  idle, can accept start
//   busy     out  adder cycles in progress
//   done     out  one-cycle pulse, Rx/Ry valid
//   Rx, Ry   out  WIDTH  result, held until the next done
// ---------------------------------------------------------------------------
module point_multiplier_seq
  import point_multiplier_seq_pkg::*;
#(
  parameter int WIDTH  = DATAWIDTH,
  parameter int LADDER = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] Qx,
  input  logic [WIDTH-1:0] Qy,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Rx,
  output logic [WIDTH-1:0] Ry
);

  localparam int IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam bit USE_LADDER = (LADDER != 0);

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] k_reg;
  logic [WIDTH-1:0] bx_reg;
  logic [WIDTH-1:0] by_reg;
  logic [WIDTH-1:0] r0x_reg;
  logic [WIDTH-1:0] r0y_reg;
  logic [WIDTH-1:0] r1x_reg;
  logic [WIDTH-1:0] r1y_reg;
  logic [WIDTH-1:0] rx_reg;
  logic [WIDTH-1:0] ry_reg;
  logic [IW-1:0]    i_reg;

  logic [WIDTH-1:0] r0x_next;
  logic [WIDTH-1:0] r0y_next;
  logic [WIDTH-1:0] r1x_next;
  logic [WIDTH-1:0] r1y_next;

  logic [WIDTH-1:0] op_ax;
  logic [WIDTH-1:0] op_ay;
  logic [WIDTH-1:0] op_bx;
  logic [WIDTH-1:0] op_by;
  logic [WIDTH-1:0] sum_x;
  logic [WIDTH-1:0] sum_y;

  logic             k_bit;
  logic             accept;
  logic             last_op;
  logic             final_op;

  assign k_bit    = k_reg[i_reg];
  assign accept   = (state_reg == ST_IDLE) && start;
  // Second operation of the current bit.
  assign last_op  = USE_LADDER ? (state_reg == ST_DBL) : (state_reg == ST_ADD);
  assign final_op = last_op && (i_reg == '0);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_next = USE_LADDER ? ST_ADD : ST_DBL;
      end
      ST_DBL: begin
        busy = 1'b1;
        if (!USE_LADDER)       state_next = ST_ADD;
        else if (i_reg == '0)  state_next = ST_FIN;
        else                   state_next = ST_ADD;
      end
      ST_ADD: begin
        busy = 1'b1;
        if (USE_LADDER)        state_next = ST_DBL;
        else if (i_reg == '0)  state_next = ST_FIN;
        else                   state_next = ST_DBL;
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- Adder operand muxes ----------------
  // Selected by state and k[i] only; never by operand values.
  always_comb begin
    op_ax = r0x_reg;
    op_ay = r0y_reg;
    op_bx = r0x_reg;
    op_by = r0y_reg;
    if (state_reg == ST_ADD) begin
      if (USE_LADDER) begin
        op_bx = r1x_reg;
        op_by = r1y_reg;
      end else begin
        op_bx = bx_reg;
        op_by = by_reg;
      end
    end else if (USE_LADDER && (state_reg == ST_DBL) && k_bit) begin
      op_ax = r1x_reg;
      op_ay = r1y_reg;
      op_bx = r1x_reg;
      op_by = r1y_reg;
    end
  end

  point_multiplier_seq_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .ax (op_ax),
    .ay (op_ay),
    .bx (op_bx),
    .by (op_by),
    .sx (sum_x),
    .sy (sum_y)
  );

  // ---------------- Result write-back ----------------
  always_comb begin
    r0x_next = r0x_reg;
    r0y_next = r0y_reg;
    r1x_next = r1x_reg;
    r1y_next = r1y_reg;
    case (state_reg)
      ST_DBL: begin
        if (USE_LADDER && k_bit) begin
          r1x_next = sum_x;
          r1y_next = sum_y;
        end else begin
          r0x_next = sum_x;
          r0y_next = sum_y;
        end
      end
      ST_ADD: begin
        if (USE_LADDER) begin
          if (k_bit) begin
            r0x_next = sum_x;
            r0y_next = sum_y;
          end else begin
            r1x_next = sum_x;
            r1y_next = sum_y;
          end
        end else if (k_bit) begin
          r0x_next = sum_x;
          r0y_next = sum_y;
        end
      end
      default: ;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg   <= '0;
      bx_reg  <= '0;
      by_reg  <= '0;
      r0x_reg <= '0;
      r0y_reg <= '0;
      r1x_reg <= '0;
      r1y_reg <= '0;
      rx_reg  <= '0;
      ry_reg  <= '0;
      i_reg   <= '0;
    end else if (accept) begin
      k_reg   <= n;
      bx_reg  <= Qx;
      by_reg  <= Qy;
      r0x_reg <= WIDTH'(INF_X);
      r0y_reg <= WIDTH'(INF_Y);
      r1x_reg <= Qx;
      r1y_reg <= Qy;
      i_reg   <= IW'(WIDTH - 1);
    end else if (busy) begin
      r0x_reg <= r0x_next;
      r0y_reg <= r0y_next;
      r1x_reg <= r1x_next;
      r1y_reg <= r1y_next;
      if (last_op && (i_reg != '0)) i_reg <= i_reg - IW'(1);
      // Outputs update only on the edge entering FIN.
      if (final_op) begin
        rx_reg <= r0x_next;
        ry_reg <= r0y_next;
      end
    end
  end

  assign Rx = rx_reg;
  assign Ry = ry_reg;

endmodule
